// File: rtl/operand_bypass_stage.sv
// ID/EX operand staging with nearest-stage forwarding, load-use hazard detection,
// writeback snoop while stalled, and port-0 store-data pipelining. Optional counters: BYP_PERF_CNT_EN.
module operand_bypass_stage #(
   parameter int DW    = 16,
   parameter int AW    = 4,
   parameter int NPORT = 2,
   parameter int NSTG  = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stall_ID_EX,
   input  logic                flush_ID_EX,
   input  logic                stall_EX_DM,
   input  logic [NPORT*DW-1:0] rf_rd,
   input  logic [NPORT*AW-1:0] rf_addr,
   input  logic [NPORT-1:0]    rf_re,
   input  logic [NSTG-1:0]     stg_we,
   input  logic [NSTG*AW-1:0]  stg_dst,
   input  logic [NSTG*DW-1:0]  stg_data,
   input  logic [NSTG-1:0]     stg_rdy,
   output logic [NPORT*DW-1:0] opnd,
   output logic                hazard,
   output logic [DW-1:0]       store_data_EX_DM,
   output logic [15:0]         byp_cnt,
   output logic [15:0]         haz_cnt,
   input  logic                cnt_clr
);

   localparam int LAST = NSTG - 1;

   logic [DW-1:0]    id_data  [NPORT];
   logic [AW-1:0]    id_addr  [NPORT];
   logic [NPORT-1:0] id_re;
   logic [DW-1:0]    fwd_opnd [NPORT];
   logic [NPORT-1:0] port_haz;
   logic [NPORT-1:0] port_fwd;
   logic             hazard_int;
   logic [DW-1:0]    store_q;

   // NOTE: the operand array is small register state, not a RAM, so it is reset like any flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_re <= '0;
         for (int p = 0; p < NPORT; p++) begin
            id_data[p] <= '0;
            id_addr[p] <= '0;
         end
      end else if (flush_ID_EX) begin
         id_re <= '0;
         for (int p = 0; p < NPORT; p++) begin
            id_data[p] <= '0;
            id_addr[p] <= '0;
         end
      end else if (!stall_ID_EX) begin
         id_re <= rf_re;
         for (int p = 0; p < NPORT; p++) begin
            id_data[p] <= rf_rd[p*DW +: DW];
            id_addr[p] <= rf_addr[p*AW +: AW];
         end
      end else begin
         // Held operands pick up writeback so they are current when the stall releases.
         for (int p = 0; p < NPORT; p++) begin
            if (id_addr[p] != '0 && stg_we[LAST] && stg_dst[LAST*AW +: AW] == id_addr[p])
               // NOTE: non-blocking keeps every flop sampling pre-edge values regardless of statement order.
               id_data[p] <= stg_data[LAST*DW +: DW];
         end
      end
   end

   // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
   always_comb begin
      logic          hit;
      logic          rdy;
      logic [DW-1:0] fdata;
      port_haz = '0;
      port_fwd = '0;
      for (int p = 0; p < NPORT; p++) begin
         hit         = 1'b0;
         rdy         = 1'b0;
         fdata       = '0;
         fwd_opnd[p] = id_data[p];
         // Walk oldest to youngest so the youngest matching stage overrides.
         for (int i = NSTG - 1; i >= 0; i--) begin
            if (stg_we[i] && stg_dst[i*AW +: AW] == id_addr[p]) begin
               hit   = 1'b1;
               rdy   = stg_rdy[i];
               fdata = stg_data[i*DW +: DW];
            end
         end
         if (id_addr[p] == '0) begin
            fwd_opnd[p] = '0;
         end else if (hit && rdy) begin
            fwd_opnd[p] = fdata;
            port_fwd[p] = 1'b1;
         end else if (hit) begin
            port_haz[p] = 1'b1;
         end
      end
      hazard_int = |(port_haz & id_re);
   end

   for (genvar p = 0; p < NPORT; p++) begin : g_opnd
      assign opnd[p*DW +: DW] = rst_n ? fwd_opnd[p] : '0;
   end
   assign hazard = rst_n & hazard_int;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         store_q <= '0;
      else if (!stall_EX_DM)
         store_q <= opnd[DW-1:0];
   end
   assign store_data_EX_DM = store_q;

`ifdef BYP_PERF_CNT_EN
   logic [15:0] byp_q;
   logic [15:0] haz_q;
   logic [15:0] byp_inc;
   logic [16:0] byp_sum;

   always_comb begin
      byp_inc = '0;
      for (int p = 0; p < NPORT; p++)
         if (id_re[p] && port_fwd[p]) byp_inc = byp_inc + 16'd1;
      byp_sum = {1'b0, byp_q} + {1'b0, byp_inc};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byp_q <= '0;
         haz_q <= '0;
      end else if (cnt_clr) begin
         byp_q <= '0;
         haz_q <= '0;
      end else begin
         if (!hazard_int && !stall_ID_EX)
            byp_q <= byp_sum[16] ? 16'hFFFF : byp_sum[15:0];
         if (hazard_int && haz_q != 16'hFFFF)
            haz_q <= haz_q + 16'd1;
      end
   end

   assign byp_cnt = byp_q;
   assign haz_cnt = haz_q;
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign byp_cnt = '0;
   assign haz_cnt = '0;
`endif

endmodule

// File: doc/operand_bypass_stage.md
# operand_bypass_stage

Parametrised ID/EX operand staging and forwarding unit for the pipelined core. It registers N register-file read ports into ID_EX and forwards results from NSTG downstream stages with nearest-stage priority. It flags load-use hazards when the nearest producer's result is not yet available, and snoops the writeback stage while ID_EX is stalled so held operands never go stale. It also pipelines port-0 store data into EX_DM.

## Interface
Parameters:
- DW, 16, datapath width
- AW, 4, register address width
- NPORT, 2, register-file read ports staged (2..4)
- NSTG, 2, forwarding stages; index 0 = EX_DM (youngest), index NSTG-1 = writeback

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- stall_ID_EX  in  1  hold ID_EX registers
- flush_ID_EX  in  1  bubble ID_EX; takes priority over stall_ID_EX
- stall_EX_DM  in  1  hold store-data register
- rf_rd  in  NPORT*DW  register-file read data; port p at [p*DW +: DW]
- rf_addr  in  NPORT*AW  register address per port
- rf_re  in  NPORT  port p is used by the instruction in ID
- stg_we  in  NSTG  stage i will write a register
- stg_dst  in  NSTG*AW  destination address per stage
- stg_data  in  NSTG*DW  result per stage
- stg_rdy  in  NSTG  stage i result valid (0 for load in EX_DM)
- opnd  out  NPORT*DW  forwarded operands for EX
- hazard  out  1  load-use hazard; ID must stall and EX must bubble
- store_data_EX_DM  out  DW  port-0 operand registered for SW
- byp_cnt  out  16  forwarded-operand count (BYP_PERF_CNT_EN only)
- haz_cnt  out  16  hazard-cycle count (BYP_PERF_CNT_EN only)
- cnt_clr  in  1  synchronous counter clear (BYP_PERF_CNT_EN only)

## Operation
- ID_EX registers per port: data, addr, re. Reset to all zero.
- flush_ID_EX=1: re and data cleared to 0, addr cleared to 0.
- Otherwise, stall_ID_EX=0: capture rf_rd, rf_addr and rf_re.
- Stall snoop: when stall_ID_EX=1 and flush=0, a held port whose addr is nonzero and matches stg_dst[NSTG-1] with stg_we[NSTG-1]=1 loads stg_data[NSTG-1]. Other held ports are unchanged.
- Address 0 is hardwired zero. It is never forwarded, never hazards, and its opnd is always 0.
- Forwarding per port: find the lowest index i with stg_we[i]=1 and stg_dst[i]=addr (addr≠0).
  - If found and stg_rdy[i]=1, opnd = stg_data[i].
  - If found and stg_rdy[i]=0, the port hazards and opnd = held data (don't-care).
  - If not found, opnd = held data.
  - An older ready stage is never used when a younger non-ready stage matches.
- hazard = OR over ports of (re & port hazards). Ports with re=0 never hazard.
- Store data: on stall_EX_DM=0, store_data_EX_DM ← opnd port 0. Reset value 0.

## Timing
- opnd and hazard are combinational from ID_EX registers and the stage buses, valid in the same cycle.
- Captured and snooped data appear on opnd the cycle after the clock edge.
- store_data_EX_DM lags opnd port 0 by one cycle.
- rst_n low asynchronously clears all registers, counters included. Outputs are 0 while reset is asserted.
- Simultaneous flush and stall: flush wins.
- Simultaneous snoop and forward from stage 0 to the same addr: stage 0 data drives opnd, and the snoop still updates the held register.

## Configuration
- BYP_PERF_CNT_EN defined:
  - byp_cnt adds the number of ports with re=1 that forwarded, in cycles where hazard=0 and stall_ID_EX=0.
  - haz_cnt increments each cycle hazard=1.
  - Both saturate at 16'hFFFF.
  - cnt_clr zeroes both and has priority over increment.
- BYP_PERF_CNT_EN undefined: no counter logic; byp_cnt and haz_cnt tie to 0 and cnt_clr is ignored.

## Test plan
- Port0 addr=3, stg_we[0]=1, stg_dst[0]=3, stg_data[0]=16'h1234, rdy=1 -> opnd port0=16'h1234, hazard=0.
- Stages 0 and 1 both target r5 (0xAAAA, 0x5555), rdy[0]=0 -> hazard=1. Clearing rdy-side condition via stg_we[0]=0 -> opnd=0x5555.
- Hold port1 addr=7 under stall, stage NSTG-1 writes r7=0xBEEF, then stage empties -> opnd port1=0xBEEF after release.
- addr=0 with stage 0 writing r0=0xFFFF -> opnd=0, hazard=0.
- flush_ID_EX and stall_ID_EX together while a matching load is pending -> next cycle re=0, hazard=0, opnd=0.
- Macro on: 3 forwarded ports over advancing cycles plus 2 hazard cycles -> byp_cnt=3, haz_cnt=2; cnt_clr -> both 0; rst_n low mid-run -> all outputs 0 immediately.
